// File: rtl/uart_tx_if.sv
// CPU-side byte handshake into the UART transmitter FIFO.
// The master offers a byte with tx_valid; the transmitter accepts it
// on any clock where tx_ready is also high.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small TX FIFO: 8N1 frames, LSB first.
// Each bit is held for baud+1 clocks. The divisor is captured when a
// frame is loaded, so a change only affects the following frame.
// Frames queued in the FIFO go out back-to-back with no idle gap.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between data[7] and the stop bit (11-bit frames instead of 10).
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [12:0]              baud,
    uart_tx_if.slave                 tx_if,
    output logic                     TX,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam logic [3:0] LAST_BIT = 4'(NBITS - 1);

    typedef enum logic {IDLE, XMIT} state_t;

    state_t             state_q, state_d;
    logic [7:0]         mem_q [DEPTH];
    logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NBITS-1:0]   shreg_q, shreg_d;
    logic [12:0]        baud_q, baud_d;
    logic [12:0]        baud_cnt_q, baud_cnt_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic               ready, push, pop, load, shift;

    // Frame image, bit 0 goes out first: start(0), data LSB first, [parity], stop(1).
    function automatic logic [NBITS-1:0] make_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    assign ready          = (cnt_q != CW'(DEPTH));
    assign push           = tx_if.tx_valid && ready;
    assign pop            = load;
    assign tx_if.tx_ready = ready;

    // The line is the LSB of the shift register; it rests at all ones when idle,
    // so TX comes straight from a flop and reset forces it high at once.
    assign TX       = shreg_q[0];
    assign busy     = (state_q == XMIT);
    assign fifo_cnt = cnt_q;

    // Next state: decide when to load a new frame and when to advance a bit.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cnt_q != '0) begin
                    load    = 1'b1;
                    state_d = XMIT;
                end
            end
            XMIT: begin
                if (baud_cnt_q == '0) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        // Stop bit complete: chain the next frame or fall idle.
                        if (cnt_q != '0) begin
                            load = 1'b1;
                        end else begin
                            shift   = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame datapath: shift register, captured divisor and bit timing counters.
    always_comb begin
        shreg_d    = shreg_q;
        baud_d     = baud_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (load) begin
            shreg_d    = make_frame(mem_q[rptr_q]);
            baud_d     = baud;
            baud_cnt_d = baud;
            bit_cnt_d  = '0;
        end else if (shift) begin
            shreg_d    = {1'b1, shreg_q[NBITS-1:1]};
            baud_cnt_d = baud_q;
            bit_cnt_d  = bit_cnt_q + 4'd1;
        end else if (state_q == XMIT) begin
            baud_cnt_d = baud_cnt_q - 13'd1;
        end
    end

    // FIFO pointer and occupancy update; simultaneous push and pop keep the count.
    always_comb begin
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Control and frame registers; reset abandons any frame and empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q    <= '1;
            baud_q     <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            shreg_q    <= shreg_d;
            baud_q     <= baud_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= tx_if.tx_data;
    end

endmodule
